// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: assembles framed read/write commands from the uart_rx byte
// stream and issues them to the register file over a valid/ready handshake.
// Optional build macro: UART_CMD_CKSUM_EN adds a trailing XOR checksum byte
// to every frame, checked in state CSUM.
module uart_cmd_ctrl #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned TIMEOUT = 24000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rcv,
  input  logic [7:0]        data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_we,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [7:0]        cmd_wdata,
  output logic              busy,
  output logic              err,
  output logic [7:0]        err_cnt
);

  localparam logic [7:0]       OP_WR    = 8'h57;
  localparam logic [7:0]       OP_RD    = 8'h52;
  localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_ISSUE
`ifdef UART_CMD_CKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t            r_state;
  logic              r_valid;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wdata;
  logic              r_busy;
  logic              r_err;
  logic [7:0]        r_err_cnt;
  logic [CNT_W-1:0]  r_tcnt;
`ifdef UART_CMD_CKSUM_EN
  logic [7:0]        r_csum;
`endif

  logic w_op_ok;
  logic w_addr_bad;
  logic w_timed;
  logic w_expire;
  logic w_err;

  assign w_op_ok    = (data == OP_WR) || (data == OP_RD);
  assign w_addr_bad = (data >> ADDR_W) != 8'd0;
`ifdef UART_CMD_CKSUM_EN
  assign w_timed    = (r_state == S_ADDR) || (r_state == S_DATA) || (r_state == S_CSUM);
`else
  assign w_timed    = (r_state == S_ADDR) || (r_state == S_DATA);
`endif
  // A byte arriving in the expiry cycle wins over the timeout.
  assign w_expire   = (r_tcnt == CNT_LAST) && !rcv;

  // Decode every frame-error event of the current cycle.
  always_comb begin
    w_err = 1'b0;
    case (r_state)
      S_IDLE:  w_err = rcv && !w_op_ok;
      S_ADDR:  w_err = rcv ? w_addr_bad : w_expire;
      S_DATA:  w_err = w_expire;
`ifdef UART_CMD_CKSUM_EN
      S_CSUM:  w_err = rcv ? (data != r_csum) : w_expire;
`endif
      S_ISSUE: w_err = rcv;
      default: w_err = 1'b0;
    endcase
  end

  // Frame FSM with inter-byte timer and registered command outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_tcnt  <= '0;
`ifdef UART_CMD_CKSUM_EN
      r_csum  <= '0;
`endif
    end else begin
      r_tcnt <= (w_timed && !rcv) ? r_tcnt + CNT_W'(1) : '0;
      case (r_state)
        S_IDLE: begin
          if (rcv && w_op_ok) begin
            r_state <= S_ADDR;
            r_busy  <= 1'b1;
            r_we    <= (data == OP_WR);
            r_addr  <= '0;
            r_wdata <= '0;
`ifdef UART_CMD_CKSUM_EN
            r_csum  <= data;
`endif
          end
        end
        S_ADDR: begin
          if (rcv) begin
            if (w_addr_bad) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_addr <= data[ADDR_W-1:0];
`ifdef UART_CMD_CKSUM_EN
              r_csum  <= r_csum ^ data;
              r_state <= r_we ? S_DATA : S_CSUM;
`else
              if (r_we) begin
                r_state <= S_DATA;
              end else begin
                r_state <= S_ISSUE;
                r_valid <= 1'b1;
              end
`endif
            end
          end else if (w_expire) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_DATA: begin
          if (rcv) begin
            r_wdata <= data;
`ifdef UART_CMD_CKSUM_EN
            r_csum  <= r_csum ^ data;
            r_state <= S_CSUM;
`else
            r_state <= S_ISSUE;
            r_valid <= 1'b1;
`endif
          end else if (w_expire) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
`ifdef UART_CMD_CKSUM_EN
        S_CSUM: begin
          if (rcv) begin
            if (data == r_csum) begin
              r_state <= S_ISSUE;
              r_valid <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else if (w_expire) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
`endif
        S_ISSUE: begin
          // Overrun bytes are dropped here; only the handshake leaves ISSUE.
          if (cmd_ready) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Error pulse and saturating error counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_err <= w_err;
      if (w_err && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign cmd_valid = r_valid;
  assign cmd_we    = r_we;
  assign cmd_addr  = r_addr;
  assign cmd_wdata = r_wdata;
  assign busy      = r_busy;
  assign err       = r_err;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: a frame-level reference model predicts
// issued commands and error events; a negedge monitor pops and compares them.
module tb_uart_cmd_ctrl;

  localparam int AW  = 4;
  localparam int TMO = 100;
`ifdef UART_CMD_CKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          rcv = 1'b0;
  logic [7:0]    data = 8'h00;
  logic          cmd_ready = 1'b0;
  logic          cmd_valid;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_wdata;
  logic          busy;
  logic          err;
  logic [7:0]    err_cnt;

  uart_cmd_ctrl #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn), .rcv(rcv), .data(data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .busy(busy),
    .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { bit we; int addr; int wdata; int rise; } cmd_t;
  typedef struct { int stamp; int cnt; } err_t;
  cmd_t cmd_q[$];
  err_t err_q[$];

  // Reference model: frame bytes collected so far, pending command, idle gap.
  logic [7:0] m_frame[$];
  bit         m_pending;
  int         m_gap;
  int         m_ecnt;

  bit mon_en = 1'b0;
  bit prev_valid = 1'b0;
  bit rand_rdy = 1'b0;

  task automatic model_reset();
    m_frame.delete();
    m_pending = 1'b0;
    m_gap     = 0;
    m_ecnt    = 0;
    cmd_q.delete();
    err_q.delete();
  endtask

  task automatic model_err(input int stamp);
    err_t e;
    if (m_ecnt < 255) m_ecnt++;
    e.stamp = stamp;
    e.cnt   = m_ecnt;
    err_q.push_back(e);
  endtask

  task automatic model_frame_done(input int stamp);
    cmd_t c;
    logic [7:0] x;
    int n;
    n = m_frame.size();
    x = 8'h00;
    for (int i = 0; i < n - 1; i++) x = x ^ m_frame[i];
    if (CK && (x != m_frame[n-1])) begin
      model_err(stamp);
    end else begin
      c.we    = (m_frame[0] == 8'h57);
      c.addr  = int'(m_frame[1]);
      c.wdata = c.we ? int'(m_frame[2]) : 0;
      c.rise  = stamp;
      cmd_q.push_back(c);
      m_pending = 1'b1;
    end
    m_frame.delete();
  endtask

  // One sampled clock cycle of inputs; outcomes become visible at cyc+1.
  task automatic model_step(input bit r, input logic [7:0] d, input bit rdy);
    int stamp;
    int need;
    stamp = cyc + 1;
    if (m_pending) begin
      if (r) model_err(stamp);
      if (rdy) m_pending = 1'b0;
    end else if (r) begin
      m_gap = 0;
      m_frame.push_back(d);
      if (m_frame.size() == 1 && d != 8'h57 && d != 8'h52) begin
        model_err(stamp);
        m_frame.delete();
      end else if (m_frame.size() == 2 && (d >> AW) != 8'h00) begin
        model_err(stamp);
        m_frame.delete();
      end
      if (m_frame.size() != 0) begin
        need = ((m_frame[0] == 8'h57) ? 3 : 2) + (CK ? 1 : 0);
        if (m_frame.size() == need) model_frame_done(stamp);
      end
    end else if (m_frame.size() != 0) begin
      m_gap++;
      if (m_gap == TMO) begin
        model_err(stamp);
        m_frame.delete();
      end
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents err or a command.
  always @(negedge clk) begin
    if (mon_en) begin
      while (err_q.size() > 0 && err_q[0].stamp < cyc) begin
        chk("err_missing_at", cyc, err_q[0].stamp);
        void'(err_q.pop_front());
      end
      if (err) begin
        if (err_q.size() == 0) begin
          chk("err_unexpected", int'(err), 0);
        end else begin
          chk("err_cycle", cyc, err_q[0].stamp);
          chk("err_cnt_at_err", int'(err_cnt), err_q[0].cnt);
          void'(err_q.pop_front());
        end
      end
      if (cmd_valid && !prev_valid) begin
        if (cmd_q.size() == 0) chk("valid_unexpected", int'(cmd_valid), 0);
        else chk("valid_rise_cycle", cyc, cmd_q[0].rise);
      end
      if (cmd_valid && cmd_ready && cmd_q.size() != 0) begin
        chk("cmd_we", int'(cmd_we), int'(cmd_q[0].we));
        chk("cmd_addr", int'(cmd_addr), cmd_q[0].addr);
        chk("cmd_wdata", int'(cmd_wdata), cmd_q[0].wdata);
        void'(cmd_q.pop_front());
      end
      prev_valid <= cmd_valid;
    end else begin
      prev_valid <= 1'b0;
    end
  end

  task automatic cycle(input bit r, input logic [7:0] d);
    if (rand_rdy) cmd_ready = ($urandom_range(0, 3) != 0);
    rcv  = r;
    data = d;
    model_step(r, d, cmd_ready);
    @(posedge clk);
    #1;
    rcv = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input int gap);
    repeat (gap) cycle(1'b0, 8'h00);
    cycle(1'b1, d);
  endtask

  task automatic send_frame(input bit we, input logic [7:0] addr, input logic [7:0] wd, input int gap);
    logic [7:0] op;
    op = we ? 8'h57 : 8'h52;
    send(op, gap);
    send(addr, gap);
    if (we) send(wd, gap);
    if (CK) send(op ^ addr ^ (we ? wd : 8'h00), gap);
  endtask

  task automatic drain();
    int n;
    n = 0;
    rand_rdy  = 1'b0;
    cmd_ready = 1'b1;
    while ((m_frame.size() != 0 || m_pending) && n < 4 * TMO) begin
      cycle(1'b0, 8'h00);
      n++;
    end
    repeat (3) cycle(1'b0, 8'h00);
    chk("drain_busy", int'(busy), 0);
    chk("drain_cmd_q", cmd_q.size(), 0);
    chk("drain_err_q", err_q.size(), 0);
  endtask

  task automatic do_reset();
    mon_en    = 1'b0;
    rstn      = 1'b0;
    rcv       = 1'b0;
    cmd_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    model_reset();
    chk("rst_valid", int'(cmd_valid), 0);
    chk("rst_we", int'(cmd_we), 0);
    chk("rst_addr", int'(cmd_addr), 0);
    chk("rst_wdata", int'(cmd_wdata), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    rstn   = 1'b1;
    mon_en = 1'b1;
  endtask

  function automatic int rand_gap();
    int r;
    r = $urandom_range(0, 99);
    if (r < 4) return $urandom_range(TMO - 2, TMO + 2);
    if (r < 60) return 0;
    return $urandom_range(1, 6);
  endfunction

  initial begin
    logic [7:0] b;
    logic [7:0] a;
    do_reset();

    // Write with cmd_ready held high.
    cmd_ready = 1'b1;
    send_frame(1'b1, 8'h03, 8'hA5, 1);
    drain();
    chk("write_err_cnt", int'(err_cnt), 0);

    // Read held under backpressure for 50 cycles.
    cmd_ready = 1'b0;
    send_frame(1'b0, 8'h0F, 8'h00, 0);
    repeat (50) cycle(1'b0, 8'h00);
    chk("bp_valid", int'(cmd_valid), 1);
    chk("bp_we", int'(cmd_we), 0);
    chk("bp_addr", int'(cmd_addr), 15);
    chk("bp_busy", int'(busy), 1);
    cmd_ready = 1'b1;
    cycle(1'b0, 8'h00);
    chk("bp_valid_after_hs", int'(cmd_valid), 0);
    chk("bp_busy_after_hs", int'(busy), 0);
    drain();

    // Bad opcode, then a bad address byte.
    send(8'h41, 0);
    send(8'h57, 3);
    send(8'h10, 0);
    drain();
    chk("malformed_err_cnt", int'(err_cnt), 2);

    // Timeout expiry, then bytes at TIMEOUT-1 and at expiry are accepted.
    send(8'h57, 0);
    send(8'h01, 0);
    repeat (TMO) cycle(1'b0, 8'h00);
    chk("timeout_err", int'(err), 1);
    chk("timeout_busy", int'(busy), 0);
    send(8'h57, 0);
    send(8'h01, 0);
    send(8'h5A, TMO - 2);
    if (CK) send(8'h57 ^ 8'h01 ^ 8'h5A, 0);
    drain();
    send(8'h57, 0);
    send(8'h01, 0);
    send(8'h6B, TMO - 1);
    if (CK) send(8'h57 ^ 8'h01 ^ 8'h6B, 0);
    drain();
    chk("timeout_err_cnt", int'(err_cnt), 3);

    // Overrun while pending, including one on the handshake cycle.
    cmd_ready = 1'b0;
    send_frame(1'b0, 8'h05, 8'h00, 0);
    repeat (5) cycle(1'b0, 8'h00);
    send(8'h33, 0);
    repeat (5) cycle(1'b0, 8'h00);
    chk("ovr_valid", int'(cmd_valid), 1);
    chk("ovr_addr", int'(cmd_addr), 5);
    chk("ovr_we", int'(cmd_we), 0);
    cmd_ready = 1'b1;
    cycle(1'b1, 8'h77);
    drain();
    chk("ovr_err_cnt", int'(err_cnt), 5);

`ifdef UART_CMD_CKSUM_EN
    // Checksum match and mismatch.
    send(8'h57, 0); send(8'h02, 0); send(8'h11, 0); send(8'h44, 0);
    drain();
    send(8'h57, 0); send(8'h02, 0); send(8'h11, 0); send(8'h45, 0);
    drain();
    chk("cksum_err_cnt", int'(err_cnt), 6);
`endif

    // Randomized traffic with random backpressure.
    for (int t = 0; t < 250; t++) begin
      rand_rdy = 1'b1;
      if ($urandom_range(0, 9) < 7) begin
        a = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
        b = ($urandom_range(0, 1) != 0) ? 8'h57 : 8'h52;
        send(b, rand_gap());
        send(a, rand_gap());
        if (b == 8'h57) begin
          send(8'($urandom_range(0, 255)), rand_gap());
          b = b ^ data;
        end
        if (CK) send((b ^ a) ^ (($urandom_range(0, 9) == 0) ? 8'h01 : 8'h00), rand_gap());
      end else begin
        send(8'($urandom_range(0, 255)), rand_gap());
      end
    end
    drain();
    chk("random_err_cnt", int'(err_cnt), m_ecnt);

    // Reset in the middle of a frame.
    send(8'h57, 0);
    send(8'h03, 0);
    do_reset();

    // 300 bad opcodes saturate the counter.
    cmd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'h57 || b == 8'h52) b = 8'h00;
      cycle(1'b1, b);
    end
    repeat (3) cycle(1'b0, 8'h00);
    chk("sat_err_cnt", int'(err_cnt), 255);
    chk("sat_busy", int'(busy), 0);
    chk("sat_err_q", err_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Command sequencer sitting between the uart_rx receiver and the on-board register/LED logic. It consumes the receiver's one-cycle `rcv` strobe and `data` byte, assembles framed read/write commands, and issues each complete command to a downstream register file over a valid/ready handshake. Malformed, overrun and stalled frames are discarded, and every discard is counted.

## Interface
- `ADDR_W`, default 4: address width; the address byte's bits above `ADDR_W` must be zero.
- `TIMEOUT`, default 24000: maximum clk cycles allowed between bytes of one frame (2 ms at 12 MHz).
- `clk` input, 1 bit: system clock.
- `rstn` input, 1 bit: reset, synchronous, active-low.
- `rcv` input, 1 bit: one-cycle strobe from uart_rx; `data` is valid in the same cycle.
- `data` input, 8 bits: received byte.
- `cmd_valid` output, 1 bit: a command is pending.
- `cmd_ready` input, 1 bit: downstream accepts the command.
- `cmd_we` output, 1 bit: 1 = write, 0 = read.
- `cmd_addr` output, `ADDR_W` bits: target register.
- `cmd_wdata` output, 8 bits: write data; 0 for reads.
- `busy` output, 1 bit: the FSM is not in IDLE.
- `err` output, 1 bit: one-cycle pulse on any frame error.
- `err_cnt` output, 8 bits: saturating error counter.

## Operation
- Frame formats:
  - Write: `0x57` ('W'), addr, wdata.
  - Read: `0x52` ('R'), addr.
- FSM states: IDLE, ADDR, DATA, CSUM, ISSUE.
- IDLE:
  - `rcv` with `0x57` goes to ADDR and sets we=1.
  - `rcv` with `0x52` goes to ADDR and sets we=0.
  - `rcv` with any other byte stays in IDLE and raises an error.
- ADDR, on `rcv`:
  - If `data[7:ADDR_W]` is nonzero: error, return to IDLE.
  - Otherwise latch the address, then go to DATA if we=1, or to ISSUE if we=0 (CSUM when checksum is enabled).
- DATA: on `rcv`, latch wdata and go to ISSUE (CSUM when checksum is enabled).
- ISSUE:
  - `cmd_valid` is held high and `cmd_we`/`cmd_addr`/`cmd_wdata` are held stable.
  - On `cmd_valid && cmd_ready`, return to IDLE.
- Overrun: any `rcv` while in ISSUE (including the handshake cycle) drops the byte and raises an error. The pending command is unaffected.
- Timeout:
  - The counter clears on entry to ADDR and on every accepted byte, and counts while in ADDR, DATA or CSUM.
  - When it reaches `TIMEOUT-1` with no `rcv`: error, return to IDLE.
  - If `rcv` and expiry occur in the same cycle, `rcv` wins.
  - There is no timeout in IDLE or ISSUE; downstream may stall indefinitely.
- Errors: `err` pulses high for one cycle; `err_cnt` increments and saturates at 255, never wrapping.
- Reset (any cycle, including mid-frame):
  - FSM returns to IDLE and any partial frame is discarded.
  - `cmd_valid`=0, `cmd_we`=0, `cmd_addr`=0, `cmd_wdata`=0, `busy`=0, `err`=0, `err_cnt`=0.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- `cmd_valid` rises in the cycle after the `rcv` of the final frame byte.
- `cmd_valid` falls in the cycle after the handshake; the earliest next `cmd_valid` is 3 cycles later, bounded in practice by the UART byte rate.
- `err` rises in the cycle after the offending `rcv`, or after the timeout expiry cycle.
- `busy` is high from the cycle after the opcode byte's `rcv` until the cycle after the handshake or error.
- The timeout error fires exactly `TIMEOUT` cycles after the last accepted byte.

## Configuration
- Macro: `UART_CMD_CKSUM_EN`.
- Defined:
  - Every frame carries a trailing checksum byte equal to the XOR of all preceding frame bytes, opcode included. It is handled in state CSUM.
  - Mismatch: error, return to IDLE, no command issued.
  - The timeout applies in CSUM.
- Undefined: state CSUM and the XOR accumulator are not built, and frames end at the addr or wdata byte.

## Test plan
- Write: send 0x57, 0x03, 0xA5 with `cmd_ready`=1 → exactly one cycle with `cmd_valid`=1, `cmd_we`=1, `cmd_addr`=3, `cmd_wdata`=0xA5; `err_cnt` stays 0.
- Read with backpressure: send 0x52, 0x0F with `cmd_ready`=0 for 50 cycles → `cmd_valid` held with addr=0xF and we=0; on `cmd_ready`=1, one handshake, then `busy`=0.
- Malformed: send 0x41, then 0x57, 0x10 → two `err` pulses, `err_cnt`=2, no `cmd_valid`.
- Timeout: with `TIMEOUT`=100, send 0x57, 0x01, then idle 100 cycles → `err` pulses on the cycle after expiry and the FSM is in IDLE. A next byte at 99 cycles, or one coinciding with expiry, must instead be accepted.
- Overrun and saturation:
  - Hold `cmd_ready`=0 and inject a `rcv` during ISSUE → byte dropped, `err_cnt`+1, pending command intact.
  - Inject 300 bad opcodes → `err_cnt`=255.
- Checksum (`UART_CMD_CKSUM_EN` defined):
  - Send 0x57, 0x02, 0x11, 0x44 → command issued.
  - Send checksum 0x45 instead → `err` pulse, no command.
